// File: rtl/code_input_cond_if.sv
// Handshake-free signal bundle between the button front end and the lock FSM.
// The master side drives buttons and FSM requests; the slave is the conditioner.
interface code_input_cond_if;
    logic [3:0] btn;
    logic       en;
    logic       encnt;
    logic       Din;
    logic       nDin;
    logic       Rin;
    logic       nRin;
    logic       anyIN;
    logic       timeOut;
    logic       cntOut;

    modport master (
        output btn, en, encnt,
        input  Din, nDin, Rin, nRin, anyIN, timeOut, cntOut
    );

    modport slave (
        input  btn, en, encnt,
        output Din, nDin, Rin, nRin, anyIN, timeOut, cntOut
    );
endinterface

// File: rtl/code_input_cond.sv
// Button sync/debounce, press classification, inactivity timer and
// attempt-count lockout feeding the code-entry lock FSM.
module code_input_cond #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int TIMEOUT_CYCLES  = 16,
    parameter int MAX_ATTEMPTS    = 3,
    parameter int LOCKOUT_CYCLES  = 32,
    parameter int D_KEY           = 0,
    parameter int R_KEY           = 1
) (
    input  logic             clk,
    input  logic             reset,
    code_input_cond_if.slave bus
);

    localparam int DBW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int TMW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam int ATW = $clog2(MAX_ATTEMPTS + 1);
    localparam int LKW = (LOCKOUT_CYCLES > 1) ? $clog2(LOCKOUT_CYCLES) : 1;

    localparam logic [DBW-1:0] DB_LAST = DBW'(DEBOUNCE_CYCLES - 1);
    localparam logic [TMW-1:0] TM_LAST = TMW'(TIMEOUT_CYCLES - 1);
    localparam logic [ATW-1:0] AT_MAX  = ATW'(MAX_ATTEMPTS);
    localparam logic [LKW-1:0] LK_LAST = LKW'(LOCKOUT_CYCLES - 1);
    localparam logic [3:0]     D_MASK  = 4'(1) << D_KEY;
    localparam logic [3:0]     R_MASK  = 4'(1) << R_KEY;

    logic [3:0]          sync1_q, sync1_d;
    logic [3:0]          sync2_q, sync2_d;
    logic [3:0]          stable_q, stable_d;
    logic [3:0]          stable_prev_q, stable_prev_d;
    logic [3:0][DBW-1:0] dbc_q, dbc_d;
    logic [TMW-1:0]      timer_q, timer_d;
    logic [ATW-1:0]      attempts_q, attempts_d;
    logic [LKW-1:0]      lock_cnt_q, lock_cnt_d;
    logic                lock_q, lock_d;
    logic                encnt_dly_q, encnt_dly_d;
    logic                din_q, din_d;
    logic                ndin_q, ndin_d;
    logic                rin_q, rin_d;
    logic                nrin_q, nrin_d;
    logic                any_q, any_d;
    logic                timeout_q, timeout_d;

    logic [3:0] press;
    logic       key_any;
    logic       d_only;
    logic       r_only;
    logic       gate;
    logic       lock_end;
    logic       encnt_rise;

    always_comb begin
        sync1_d       = bus.btn;
        sync2_d       = sync1_q;
        stable_d      = stable_q;
        dbc_d         = '0;
        stable_prev_d = stable_q;

        // A key flips only after DEBOUNCE_CYCLES consecutive mismatches
        for (int k = 0; k < 4; k++) begin
            if (sync2_q[k] != stable_q[k]) begin
                if (dbc_q[k] == DB_LAST) begin
                    stable_d[k] = ~stable_q[k];
                end else begin
                    dbc_d[k] = dbc_q[k] + DBW'(1);
                end
            end
        end

        press   = stable_q & ~stable_prev_q;
        key_any = |press;
        d_only  = (press == D_MASK);
        r_only  = (press == R_MASK);

        encnt_dly_d = bus.encnt;
        encnt_rise  = bus.encnt & ~encnt_dly_q;
        lock_end    = lock_q && (lock_cnt_q == LK_LAST);

        attempts_d = attempts_q;
        if (lock_end) begin
            attempts_d = '0;
        end else if (!lock_q && encnt_rise && attempts_q != AT_MAX) begin
            attempts_d = attempts_q + ATW'(1);
        end

        lock_d     = lock_q ? !lock_end : (attempts_q == AT_MAX);
        lock_cnt_d = '0;
        if (lock_q && !lock_end) begin
            lock_cnt_d = lock_cnt_q + LKW'(1);
        end

        // Outputs are gated by the next lock level so no pulse overlaps cntOut
        gate = ~lock_d;

        timer_d = '0;
        if (bus.en && !key_any && !lock_q && !lock_d && timer_q != TM_LAST) begin
            timer_d = timer_q + TMW'(1);
        end

        timeout_d = gate & ~lock_q & bus.en & ~key_any & (timer_q == TM_LAST);
        din_d     = gate & d_only;
        ndin_d    = gate & key_any & ~d_only;
        rin_d     = gate & r_only;
        nrin_d    = gate & key_any & ~r_only;
        any_d     = gate & key_any;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q       <= '0;
            sync2_q       <= '0;
            stable_q      <= '0;
            stable_prev_q <= '0;
            dbc_q         <= '0;
            timer_q       <= '0;
            attempts_q    <= '0;
            lock_cnt_q    <= '0;
            lock_q        <= 1'b0;
            encnt_dly_q   <= 1'b0;
            din_q         <= 1'b0;
            ndin_q        <= 1'b0;
            rin_q         <= 1'b0;
            nrin_q        <= 1'b0;
            any_q         <= 1'b0;
            timeout_q     <= 1'b0;
        end else begin
            sync1_q       <= sync1_d;
            sync2_q       <= sync2_d;
            stable_q      <= stable_d;
            stable_prev_q <= stable_prev_d;
            dbc_q         <= dbc_d;
            timer_q       <= timer_d;
            attempts_q    <= attempts_d;
            lock_cnt_q    <= lock_cnt_d;
            lock_q        <= lock_d;
            encnt_dly_q   <= encnt_dly_d;
            din_q         <= din_d;
            ndin_q        <= ndin_d;
            rin_q         <= rin_d;
            nrin_q        <= nrin_d;
            any_q         <= any_d;
            timeout_q     <= timeout_d;
        end
    end

    assign bus.Din     = din_q;
    assign bus.nDin    = ndin_q;
    assign bus.Rin     = rin_q;
    assign bus.nRin    = nrin_q;
    assign bus.anyIN   = any_q;
    assign bus.timeOut = timeout_q;
    assign bus.cntOut  = lock_q;

endmodule

// File: tb/tb_code_input_cond.sv
// Directed bench for code_input_cond: key events, timer, lockout and reset.
// Output vector order: {Din, nDin, Rin, nRin, anyIN, timeOut, cntOut}.
module tb_code_input_cond;

    localparam logic [6:0] EV_0  = 7'b0000000;
    localparam logic [6:0] EV_D  = 7'b1001100;
    localparam logic [6:0] EV_DR = 7'b0101100;
    localparam logic [6:0] EV_T  = 7'b0000010;
    localparam logic [6:0] EV_L  = 7'b0000001;

    logic clk;
    logic reset;
    int   n_cmp;
    int   n_err;

    code_input_cond_if ifc ();

    code_input_cond dut (
        .clk   (clk),
        .reset (reset),
        .bus   (ifc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [6:0] exp);
        logic [6:0] obs;
        obs = {ifc.Din, ifc.nDin, ifc.Rin, ifc.nRin,
               ifc.anyIN, ifc.timeOut, ifc.cntOut};
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    initial begin
        n_cmp     = 0;
        n_err     = 0;
        reset     = 1'b1;
        ifc.btn   = 4'b0000;
        ifc.en    = 1'b0;
        ifc.encnt = 1'b0;
        step(2);
        check("reset", EV_0);
        reset = 1'b0;

        // Single D press, held 20 cycles, then released
        ifc.btn = 4'b0001;
        for (int i = 1; i <= 32; i++) begin
            step(1);
            check($sformatf("press_d[%0d]", i), (i == 7) ? EV_D : EV_0);
            if (i == 20) ifc.btn = 4'b0000;
        end

        // 3-cycle glitch on R, then D+R together
        ifc.btn = 4'b0010;
        for (int i = 1; i <= 40; i++) begin
            step(1);
            check($sformatf("glitch_dr[%0d]", i), (i == 22) ? EV_DR : EV_0);
            if (i == 3)  ifc.btn = 4'b0000;
            if (i == 15) ifc.btn = 4'b0011;
            if (i == 30) ifc.btn = 4'b0000;
        end

        // Idle timer with en=1
        ifc.en = 1'b1;
        for (int i = 1; i <= 40; i++) begin
            step(1);
            check($sformatf("timer[%0d]", i),
                  (i == 16 || i == 32) ? EV_T : EV_0);
        end
        ifc.en = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            step(1);
            check($sformatf("en_off[%0d]", i), EV_0);
        end

        // Press at cycle 10 restarts the timer
        ifc.en = 1'b1;
        for (int i = 1; i <= 30; i++) begin
            step(1);
            check($sformatf("timer_press[%0d]", i),
                  (i == 10) ? EV_D : (i == 26) ? EV_T : EV_0);
            if (i == 3) ifc.btn = 4'b0001;
        end
        ifc.btn = 4'b0000;
        ifc.en  = 1'b0;
        for (int i = 1; i <= 12; i++) begin
            step(1);
            check($sformatf("settle1[%0d]", i), EV_0);
        end

        // Press on the timer terminal cycle: press wins
        ifc.en = 1'b1;
        for (int i = 1; i <= 33; i++) begin
            step(1);
            check($sformatf("press_term[%0d]", i),
                  (i == 16) ? EV_D : (i == 32) ? EV_T : EV_0);
            if (i == 9) ifc.btn = 4'b0001;
        end
        ifc.btn = 4'b0000;
        ifc.en  = 1'b0;
        for (int i = 1; i <= 12; i++) begin
            step(1);
            check($sformatf("settle2[%0d]", i), EV_0);
        end

        // Three encnt windows lock; press and en inside lockout are muted
        for (int i = 1; i <= 48; i++) begin
            ifc.encnt = (i == 1 || i == 2 || i == 5 || i == 6 ||
                         i == 9 || i == 10);
            ifc.en    = (i >= 12 && i < 38);
            ifc.btn   = (i >= 12 && i < 38) ? 4'b0001 : 4'b0000;
            step(1);
            check($sformatf("lock[%0d]", i),
                  (i >= 10 && i <= 41) ? EV_L : EV_0);
        end

        // Held encnt counts once; two more rises then lock
        for (int i = 1; i <= 25; i++) begin
            ifc.encnt = (i <= 10 || i == 13 || i == 14 ||
                         i == 17 || i == 18);
            step(1);
            check($sformatf("held[%0d]", i), (i >= 18) ? EV_L : EV_0);
        end

        // Reset mid-lockout, then three fresh rises are needed
        reset     = 1'b1;
        ifc.encnt = 1'b0;
        step(1);
        check("rst_lock", EV_0);
        reset = 1'b0;
        for (int i = 1; i <= 12; i++) begin
            ifc.encnt = (i == 1 || i == 2 || i == 5 || i == 6 ||
                         i == 9 || i == 10);
            step(1);
            check($sformatf("relock[%0d]", i), (i >= 10) ? EV_L : EV_0);
        end

        // Button held through a mid-debounce reset re-qualifies fully
        ifc.encnt = 1'b0;
        ifc.btn   = 4'b0001;
        step(3);
        reset = 1'b1;
        step(1);
        check("rst_deb", EV_0);
        reset = 1'b0;
        for (int i = 1; i <= 12; i++) begin
            step(1);
            check($sformatf("requal[%0d]", i), (i == 7) ? EV_D : EV_0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule
